ls_port_arbiter: RTL and testbench

Arbitrates the single local-store (LS) port of the SPU between three requesters: the odd-pipe load/store unit, the DMA engine and instruction fetch. It grants at most one quadword access per cycle, drives the registered LS address/data/write-enable, and returns read data with a per-requester valid strobe. Taken branches squash fetch traffic. The block sits between the odd pipe, DMA and fetch logic on one side and the local-store memory on the other.

---
 rtl/ls_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_ls_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_port_arbiter.sv
// ls_port_arbiter: single local-store port arbiter for the odd pipe, DMA and
// instruction fetch, with registered LS port drive and per-requester rvalid.
// Ports: clock/reset; op_*, dma_*, if_* request side; *_gnt combinational
// grants; *_rvalid + rdata read return; branch_taken squashes fetch;
// ls_address/ls_data_input/ls_wrt_en/ls_rd_en drive the LS, ls_data_output
// returns LS read data one cycle after ls_rd_en.
// Option: define LS_ARB_STARVE_GUARD_EN to enable fetch starvation promotion
// after STARVE_LIMIT blocked cycles; otherwise priority is strictly fixed.
module ls_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         op_req,
  input  logic         dma_req,
  input  logic         if_req,
  input  logic         op_we,
  input  logic         dma_we,
  input  logic [14:0]  op_addr,
  input  logic [14:0]  dma_addr,
  input  logic [14:0]  if_addr,
  input  logic [127:0] op_wdata,
  input  logic [127:0] dma_wdata,
  output logic         op_gnt,
  output logic         dma_gnt,
  output logic         if_gnt,
  output logic         op_rvalid,
  output logic         dma_rvalid,
  output logic         if_rvalid,
  output logic [127:0] rdata,
  input  logic         branch_taken,
  output logic [14:0]  ls_address,
  output logic [127:0] ls_data_input,
  output logic         ls_wrt_en,
  output logic         ls_rd_en,
  input  logic [127:0] ls_data_output
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_OP,
    OWN_DMA,
    OWN_IF
  } owner_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  // Quadword alignment: the low nibble of the byte address never reaches
  // the LS.
  localparam logic [14:0] QW_MASK = 15'h7FF0;

  logic         if_ok;
  logic         promote;
  logic         xfer;
  logic         sel_we;
  logic [14:0]  sel_addr;
  logic [127:0] sel_wdata;
  owner_t       sel_own;
  owner_t       rd_owner;

  // A taken branch blocks fetch from being granted at all.
  assign if_ok = if_req & ~branch_taken;

`ifdef LS_ARB_STARVE_GUARD_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] starve_cnt;

  assign promote = if_ok && (starve_cnt >= LIMIT);

  // Counts cycles fetch has been refused; a branch cycle holds the count
  // since fetch is not competing then. Saturates so it never wraps to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= 8'd0;
    end else if (!branch_taken && starve_cnt != 8'hFF) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    op_gnt  = 1'b0;
    dma_gnt = 1'b0;
    if_gnt  = 1'b0;
    if (!reset) begin
      if (promote) begin
        if_gnt = 1'b1;
      end else if (op_req) begin
        op_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end else if (if_ok) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign xfer = op_gnt | dma_gnt | if_gnt;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = if_addr;
    sel_wdata = op_wdata;
    sel_own   = OWN_IF;
    if (op_gnt) begin
      sel_we    = op_we;
      sel_addr  = op_addr;
      sel_wdata = op_wdata;
      sel_own   = OWN_OP;
    end else if (dma_gnt) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
      sel_own   = OWN_DMA;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ls_address    <= 15'd0;
      ls_data_input <= 128'd0;
      ls_wrt_en     <= 1'b0;
      ls_rd_en      <= 1'b0;
      rd_owner      <= OWN_NONE;
      op_rvalid     <= 1'b0;
      dma_rvalid    <= 1'b0;
      if_rvalid     <= 1'b0;
    end else begin
      ls_wrt_en <= xfer & sel_we;
      ls_rd_en  <= xfer & ~sel_we;
      if (xfer) begin
        ls_address <= sel_addr & QW_MASK;
      end
      if (xfer && sel_we) begin
        ls_data_input <= sel_wdata;
      end
      rd_owner   <= (xfer && !sel_we) ? sel_own : OWN_NONE;
      op_rvalid  <= (rd_owner == OWN_OP);
      dma_rvalid <= (rd_owner == OWN_DMA);
      // A fetch read still in flight when a branch is taken is dropped.
      if_rvalid  <= (rd_owner == OWN_IF) && !branch_taken;
    end
  end

  // Data is forced to zero when no requester is being served.
  assign rdata = (op_rvalid | dma_rvalid | if_rvalid) ? ls_data_output
                                                      : 128'd0;

endmodule

// File: tb/tb_ls_port_arbiter.sv
// tb_ls_port_arbiter: scoreboard bench for ls_port_arbiter with an LS model.
// Expected read results are queued at accept and compared on *_rvalid.
module tb_ls_port_arbiter;

  localparam int LIMIT = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         op_req, dma_req, if_req;
  logic         op_we, dma_we;
  logic [14:0]  op_addr, dma_addr, if_addr;
  logic [127:0] op_wdata, dma_wdata;
  logic         op_gnt, dma_gnt, if_gnt;
  logic         op_rvalid, dma_rvalid, if_rvalid;
  logic [127:0] rdata;
  logic         branch_taken;
  logic [14:0]  ls_address;
  logic [127:0] ls_data_input;
  logic         ls_wrt_en, ls_rd_en;
  logic [127:0] ls_data_output;

  always #5 clock = ~clock;

  ls_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock),
    .reset(reset),
    .op_req(op_req),
    .dma_req(dma_req),
    .if_req(if_req),
    .op_we(op_we),
    .dma_we(dma_we),
    .op_addr(op_addr),
    .dma_addr(dma_addr),
    .if_addr(if_addr),
    .op_wdata(op_wdata),
    .dma_wdata(dma_wdata),
    .op_gnt(op_gnt),
    .dma_gnt(dma_gnt),
    .if_gnt(if_gnt),
    .op_rvalid(op_rvalid),
    .dma_rvalid(dma_rvalid),
    .if_rvalid(if_rvalid),
    .rdata(rdata),
    .branch_taken(branch_taken),
    .ls_address(ls_address),
    .ls_data_input(ls_data_input),
    .ls_wrt_en(ls_wrt_en),
    .ls_rd_en(ls_rd_en),
    .ls_data_output(ls_data_output)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // Local-store model: one-cycle synchronous read.
  logic [127:0] mem [2048];
  logic [127:0] ref_mem [2048];
  bit init_mem;

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
    end else begin
      if (ls_wrt_en) mem[ls_address[14:4]] <= ls_data_input;
      if (ls_rd_en) ls_data_output <= mem[ls_address[14:4]];
    end
  end

  typedef struct {
    logic [2:0]   who;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   ncyc = 0;
  logic [2:0] rv;

  assign rv = {op_rvalid, dma_rvalid, if_rvalid};

  always @(negedge clock) begin
    if (!reset && rv != 3'b000) begin
      if (sb.size() == 0) begin
        chk("rv_unexp", 128'(rv), 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_who", 128'(rv), 128'(mon_e.who));
        chk("rv_data", rdata, mon_e.data);
        chk("rv_lat", 128'(ncyc), 128'(mon_e.due));
      end
    end
    ncyc <= ncyc + 1;
  end

  logic [14:0] last_addr;

  // Called at posedge+1 with inputs already driven; checks the grant,
  // records the expected read, then checks the LS port after the edge.
  task automatic step(input logic [2:0] exp_g, input bit push, input bit keep);
    logic         we;
    logic [14:0]  a;
    logic [127:0] wd;
    bit           xw, xr;
    #1;
    chk("gnt", 128'({op_gnt, dma_gnt, if_gnt}), 128'(exp_g));
    we = 1'b0;
    a  = if_addr;
    wd = '0;
    if (exp_g[2]) begin
      we = op_we; a = op_addr; wd = op_wdata;
    end else if (exp_g[1]) begin
      we = dma_we; a = dma_addr; wd = dma_wdata;
    end
    xw = (exp_g != 3'b000) && we;
    xr = (exp_g != 3'b000) && !we;
    if (xw) ref_mem[a[14:4]] = wd;
    if (xr && push) sb.push_back('{exp_g, ref_mem[a[14:4]], ncyc + 2});
    if (exp_g != 3'b000) last_addr = a & 15'h7FF0;
    @(posedge clock);
    #1;
    chk("ls_wrt_en", 128'(ls_wrt_en), 128'(xw));
    chk("ls_rd_en", 128'(ls_rd_en), 128'(xr));
    chk("ls_address", 128'(ls_address), 128'(last_addr));
    if (xw) chk("ls_data_input", ls_data_input, wd);
    if (!keep) begin
      if (exp_g[2]) op_req = 1'b0;
      if (exp_g[1]) dma_req = 1'b0;
      if (exp_g[0]) if_req = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 128'({op_gnt, dma_gnt, if_gnt}), 128'd0);
    chk({tag, "_rv"}, 128'(rv), 128'd0);
    chk({tag, "_wr"}, 128'(ls_wrt_en), 128'd0);
    chk({tag, "_rd"}, 128'(ls_rd_en), 128'd0);
    chk({tag, "_addr"}, 128'(ls_address), 128'd0);
    chk({tag, "_wdat"}, ls_data_input, 128'd0);
    chk({tag, "_rdata"}, rdata, 128'd0);
  endtask

  initial begin
    reset = 1'b1;
    init_mem = 1'b1;
    op_req = 0; dma_req = 0; if_req = 0;
    op_we = 0; dma_we = 0;
    op_addr = '0; dma_addr = '0; if_addr = '0;
    op_wdata = '0; dma_wdata = '0;
    branch_taken = 0;
    last_addr = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    init_mem = 1'b0;
    reset = 1'b0;
    step(3'b000, 0, 0);

    // All three request reads at once: op, then dma, then fetch.
    op_req = 1; op_addr = 15'h0040;
    dma_req = 1; dma_addr = 15'h0200;
    if_req = 1; if_addr = 15'h0300;
    step(3'b100, 1, 0);
    step(3'b010, 1, 0);
    step(3'b001, 1, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // DMA write then op read of the same quadword, back to back.
    dma_req = 1; dma_we = 1; dma_addr = 15'h0100;
    dma_wdata = {16{8'hA5}};
    step(3'b010, 1, 0);
    dma_we = 0;
    op_req = 1; op_addr = 15'h010F;
    step(3'b100, 1, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Fetch read squashed by a branch in the following cycle.
    if_req = 1; if_addr = 15'h0300;
    step(3'b001, 0, 0);
    branch_taken = 1; if_req = 1; if_addr = 15'h0310;
    step(3'b000, 0, 0);
    chk("if_rvalid_sq", 128'(if_rvalid), 128'd0);
    branch_taken = 0; if_req = 0;
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);

    // Odd pipe hogging the port while fetch waits.
    op_req = 1; op_addr = 15'h0040;
    if_req = 1; if_addr = 15'h0300;
`ifdef LS_ARB_STARVE_GUARD_EN
    for (int i = 0; i < LIMIT; i++) step(3'b100, 1, 1);
    step(3'b001, 1, 1);
    step(3'b100, 1, 1);
`else
    for (int i = 0; i < 50; i++) step(3'b100, 1, 1);
`endif
    op_req = 0; if_req = 0;
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    chk("sb_drain1", 128'(sb.size()), 128'd0);

    // Reset in the cycle after an op read is accepted.
    op_req = 1; op_addr = 15'h0040;
    step(3'b100, 0, 0);
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clock);
    #1;
    chk_zero("rst_hold");
    reset = 1'b0;
    last_addr = '0;
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    step(3'b000, 0, 0);
    chk("sb_drain2", 128'(sb.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
